pipeline_controller: RTL and testbench
======================================

// Module: pipeline_controller
// PURPOSE
//  Sequences the 3-stage pipeline datapath (IF | ID+EX | MEM+WB). Decodes the IF_ID
//  instruction, drives EX-stage selects, and registers MEM/WB controls one stage later.
//  Resolves branches in EX and generates the PC-select and IF_ID flush.
//  Also flags RAW hazards that the forwarding-less datapath cannot resolve.
// PARAMETERS
//  CNT_W  32  width of the performance counters (used only with PIPE_CTRL_PERF_EN)
// PORTS
//  clk           in   1      clock, rising edge
//  rst           in   1      synchronous reset, active-high
//  inst_control  in   7      opcode of EX instruction (instq[6:0])
//  inst_alu      in   10     {funct7,funct3} of EX instruction
//  ex_rs1        in   5      instq[19:15]
//  ex_rs2        in   5      instq[24:20]
//  mem_rd        in   5      instq1[11:7]
//  zero_flag     in   1      ALU zero of EX instruction
//  sel           out  1      PC mux: 0=pc+4, 1=branch target
//  flush         out  1      IF_ID flush
//  alu_src       out  1      ALU B: 0=rd2, 1=imm
//  alu_op        out  4      ALU operation
//  regwq         out  1      MEM/WB register write enable
//  memwq         out  1      MEM data-memory write
//  memrq         out  1      MEM data-memory read
//  mem2regq      out  1      WB mux: 0=ALU, 1=memory
//  illegal       out  1      EX opcode unsupported (1-cycle pulse per instruction)
//  raw_hazard    out  1      EX reads the reg that MEM/WB is writing
//  cycle_cnt     out  CNT_W  perf: cycles since reset
//  retired_cnt   out  CNT_W  perf: valid instructions leaving MEM/WB
//  flush_cnt     out  CNT_W  perf: taken branches
// BEHAVIOUR
//  Decode, EX instruction (combinational; all outputs 0 when ex_valid=0):
//   0110011 R:  alu_src=0, op from inst_alu, regw
//   0010011 I:  alu_src=1, op from funct3 (SRAI when funct7[5]=1), regw
//   0000011 LW: alu_src=1, ADD, memr, regw, mem2reg
//   0100011 SW: alu_src=1, ADD, memw
//   1100011 BEQ (f3=000) / BNE (f3=001): alu_src=0, SUB, no writes
//   other opcode or branch funct3: NOP, illegal=1
//  alu_op: AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110,
//   SRA=0111, SLT=1000. R-type: 0000000/f3 selects ADD..AND; 0100000/000=SUB,
//   0100000/101=SRA; any other R-type encoding is illegal.
//  ex_valid reg: reset 0; next = ~flush. The first cycle after reset is a bubble.
//  Branch: taken = ex_valid & branch & (zero_flag ^ f3[0]).
//   sel = flush = taken, combinational, same cycle.
//   The wrong-path instruction is squashed, so the penalty is 1 cycle.
//  MEM/WB regs {regwq,memwq,memrq,mem2regq}: reset 0.
//   They load the decoded EX controls qualified by ex_valid, giving 1-cycle latency.
//   They load 0 on illegal or branch.
//  raw_hazard = ex_valid & regwq & (mem_rd!=0) & ((mem_rd==ex_rs1) | (uses_rs2 & mem_rd==ex_rs2)).
//   uses_rs2 is true for R, SW and branch. Flag only; no stall.
//  Back-to-back taken branches: the second is in the flushed slot, so it is never taken.
//  rst asserted mid-stream: all regs clear next edge; in-flight writes are dropped.
// CONFIGURATION
//  PIPE_CTRL_PERF_EN defined:
//   - cycle_cnt increments every non-reset cycle.
//   - retired_cnt increments when a valid non-illegal instruction leaves MEM/WB.
//   - flush_cnt increments on each taken.
//   - All three wrap at 2^CNT_W and are 0 on reset.
//  PIPE_CTRL_PERF_EN undefined: counter ports remain and are tied to 0; no flops.
// TESTING
//  1 Reset, then ADD x3,x1,x2 (0x002081B3) -> first cycle all outputs 0;
//    next cycle alu_op=0010, alu_src=0; cycle after: regwq=1, mem2regq=0.
//  2 LW x5,4(x1) (0x0040A283) -> alu_src=1, alu_op=0010;
//    next cycle memrq=1, regwq=1, mem2regq=1, memwq=0.
//  3 BEQ with zero_flag=1 -> sel=1, flush=1 same cycle; next cycle all MEM/WB=0;
//    BNE with zero_flag=1 -> sel=0.
//  4 Taken branch followed by a taken-pattern branch in the next slot -> second flush=0
//    (ex_valid=0); flush_cnt +1 only.
//  5 Opcode 0x7F and R-type funct7=0x01 -> illegal=1, regwq/memwq stay 0 next cycle.
//  6 ADD x3 then SUB x4,x3,x1 -> raw_hazard=1 in the SUB EX cycle;
//    with rd=x0 -> raw_hazard=0.

Source files
------------

// File: rtl/pipeline_controller.sv
// pipeline_controller: EX decode, branch resolve, MEM/WB controls and RAW flag for a 3-stage pipe
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipeline_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       inst_control,
  input  logic [9:0]       inst_alu,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic [4:0]       mem_rd,
  input  logic             zero_flag,
  output logic             sel,
  output logic             flush,
  output logic             alu_src,
  output logic [3:0]       alu_op,
  output logic             regwq,
  output logic             memwq,
  output logic             memrq,
  output logic             mem2regq,
  output logic             illegal,
  output logic             raw_hazard,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [3:0] A_AND = 4'b0000;
  localparam logic [3:0] A_OR  = 4'b0001;
  localparam logic [3:0] A_ADD = 4'b0010;
  localparam logic [3:0] A_XOR = 4'b0011;
  localparam logic [3:0] A_SLL = 4'b0100;
  localparam logic [3:0] A_SRL = 4'b0101;
  localparam logic [3:0] A_SUB = 4'b0110;
  localparam logic [3:0] A_SRA = 4'b0111;
  localparam logic [3:0] A_SLT = 4'b1000;
  logic [6:0] f7;
  logic [2:0] f3;
  logic       ex_valid_q, ex_valid_d;
  logic [3:0] mw_q, mw_d;
  logic [3:0] f_op, r_op, dec_op, dec_ctl;
  logic       r_ok, dec_src, dec_ill, dec_br, dec_rs2, taken;
  assign f7 = inst_alu[9:3];
  assign f3 = inst_alu[2:0];
  always_comb begin
    f_op = A_ADD;
    case (f3)
      3'b001:         f_op = A_SLL;
      3'b010, 3'b011: f_op = A_SLT;
      3'b100:         f_op = A_XOR;
      3'b101:         f_op = f7[5] ? A_SRA : A_SRL;
      3'b110:         f_op = A_OR;
      3'b111:         f_op = A_AND;
      default:        f_op = A_ADD;
    endcase
  end
  assign r_ok = (f7 == 7'b0000000) | ((f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101)));
  assign r_op = (f7[5] & (f3 == 3'b000)) ? A_SUB : f_op;
  // ctl order is {regw, memw, memr, mem2reg}; illegal and branch leave it zero
  always_comb begin
    dec_src = 1'b0;
    dec_op  = A_AND;
    dec_ctl = 4'b0000;
    dec_ill = 1'b0;
    dec_br  = 1'b0;
    dec_rs2 = 1'b0;
    case (inst_control)
      OP_R: begin
        dec_rs2 = 1'b1;
        dec_ill = ~r_ok;
        dec_op  = r_ok ? r_op : A_AND;
        dec_ctl = r_ok ? 4'b1000 : 4'b0000;
      end
      OP_I: begin
        dec_src = 1'b1;
        dec_op  = f_op;
        dec_ctl = 4'b1000;
      end
      OP_LW: begin
        dec_src = 1'b1;
        dec_op  = A_ADD;
        dec_ctl = 4'b1011;
      end
      OP_SW: begin
        dec_src = 1'b1;
        dec_op  = A_ADD;
        dec_ctl = 4'b0100;
        dec_rs2 = 1'b1;
      end
      OP_BR: begin
        dec_rs2 = 1'b1;
        dec_br  = (f3[2:1] == 2'b00);
        dec_ill = (f3[2:1] != 2'b00);
        dec_op  = dec_br ? A_SUB : A_AND;
      end
      default: dec_ill = 1'b1;
    endcase
  end
  assign taken      = ex_valid_q & dec_br & (zero_flag ^ f3[0]);
  assign sel        = taken;
  assign flush      = taken;
  assign alu_src    = ex_valid_q & dec_src;
  assign alu_op     = ex_valid_q ? dec_op : A_AND;
  assign illegal    = ex_valid_q & dec_ill;
  assign raw_hazard = ex_valid_q & regwq & (mem_rd != 5'd0) &
                      ((mem_rd == ex_rs1) | (dec_rs2 & (mem_rd == ex_rs2)));
  assign ex_valid_d = ~taken;
  assign mw_d       = ex_valid_q ? dec_ctl : 4'b0000;
  assign {regwq, memwq, memrq, mem2regq} = mw_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid_q <= 1'b0;
      mw_q       <= 4'b0000;
    end else begin
      ex_valid_q <= ex_valid_d;
      mw_q       <= mw_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic             mv_q;
  logic [CNT_W-1:0] cyc_q, ret_q, fl_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q  <= 1'b0;
      cyc_q <= '0;
      ret_q <= '0;
      fl_q  <= '0;
    end else begin
      mv_q  <= ex_valid_q & ~dec_ill;
      cyc_q <= cyc_q + 1'b1;
      ret_q <= ret_q + CNT_W'(mv_q);
      fl_q  <= fl_q + CNT_W'(taken);
    end
  end
  assign cycle_cnt   = cyc_q;
  assign retired_cnt = ret_q;
  assign flush_cnt   = fl_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
  assign flush_cnt   = '0;
`endif
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: scoreboard bench for pipeline_controller
module tb_pipeline_controller;
  localparam int CNT_W = 32;
  logic             clk = 1'b0;
  logic             rst;
  logic [6:0]       inst_control;
  logic [9:0]       inst_alu;
  logic [4:0]       ex_rs1, ex_rs2, mem_rd;
  logic             zero_flag;
  logic             sel, flush, alu_src, regwq, memwq, memrq, mem2regq, illegal, raw_hazard;
  logic [3:0]       alu_op;
  logic [CNT_W-1:0] cycle_cnt, retired_cnt, flush_cnt;
  int checks = 0;
  int errors = 0;
  typedef struct packed {
    logic       ill, br, rs2, src;
    logic [3:0] op, ctl;
  } dec_t;
  logic [8:0]  exq[$];
  logic [3:0]  mwq[$];
  logic [31:0] prev;
  logic        m_valid, m_mv;
  logic [3:0]  m_mw;
  int          m_cyc, m_ret, m_fl;
  logic [31:0] tbl [14];
  pipeline_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .inst_control(inst_control), .inst_alu(inst_alu),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .mem_rd(mem_rd), .zero_flag(zero_flag),
    .sel(sel), .flush(flush), .alu_src(alu_src), .alu_op(alu_op),
    .regwq(regwq), .memwq(memwq), .memrq(memrq), .mem2regq(mem2regq),
    .illegal(illegal), .raw_hazard(raw_hazard),
    .cycle_cnt(cycle_cnt), .retired_cnt(retired_cnt), .flush_cnt(flush_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic dec_t model(input logic [31:0] i);
    dec_t d;
    logic [2:0] f3;
    logic [6:0] f7;
    d  = '0;
    f3 = i[14:12];
    f7 = i[31:25];
    case (i[6:0])
      7'h33: begin
        d.rs2 = 1'b1;
        d.ctl = 4'b1000;
        case ({f7, f3})
          10'b0000000_000: d.op = 4'b0010;
          10'b0000000_001: d.op = 4'b0100;
          10'b0000000_010: d.op = 4'b1000;
          10'b0000000_011: d.op = 4'b1000;
          10'b0000000_100: d.op = 4'b0011;
          10'b0000000_101: d.op = 4'b0101;
          10'b0000000_110: d.op = 4'b0001;
          10'b0000000_111: d.op = 4'b0000;
          10'b0100000_000: d.op = 4'b0110;
          10'b0100000_101: d.op = 4'b0111;
          default: begin d.ill = 1'b1; d.ctl = 4'b0000; end
        endcase
      end
      7'h13: begin
        d.src = 1'b1;
        d.ctl = 4'b1000;
        case (f3)
          3'd0: d.op = 4'b0010;
          3'd1: d.op = 4'b0100;
          3'd2, 3'd3: d.op = 4'b1000;
          3'd4: d.op = 4'b0011;
          3'd5: d.op = f7[5] ? 4'b0111 : 4'b0101;
          3'd6: d.op = 4'b0001;
          default: d.op = 4'b0000;
        endcase
      end
      7'h03: begin d.src = 1'b1; d.op = 4'b0010; d.ctl = 4'b1011; end
      7'h23: begin d.src = 1'b1; d.op = 4'b0010; d.ctl = 4'b0100; d.rs2 = 1'b1; end
      7'h63: begin
        d.rs2 = 1'b1;
        if (f3 == 3'd0 || f3 == 3'd1) begin d.br = 1'b1; d.op = 4'b0110; end
        else d.ill = 1'b1;
      end
      default: d.ill = 1'b1;
    endcase
    return d;
  endfunction
  task automatic counters();
`ifdef PIPE_CTRL_PERF_EN
    chk("cycle_cnt", cycle_cnt, m_cyc);
    chk("retired_cnt", retired_cnt, m_ret);
    chk("flush_cnt", flush_cnt, m_fl);
`else
    chk("cnt_tied", {cycle_cnt | retired_cnt | flush_cnt}, 32'd0);
`endif
  endtask
  task automatic do_reset();
    rst = 1'b1;
    {inst_control, inst_alu, ex_rs1, ex_rs2, mem_rd, zero_flag} = '0;
    @(posedge clk);
    #1;
    chk("rst_ex", {sel, flush, alu_src, alu_op, illegal, raw_hazard}, 32'd0);
    chk("rst_mw", {regwq, memwq, memrq, mem2regq}, 32'd0);
    rst = 1'b0;
    prev = '0; m_valid = 1'b0; m_mv = 1'b0; m_mw = '0;
    m_cyc = 0; m_ret = 0; m_fl = 0;
    exq.delete(); mwq.delete();
    mwq.push_back(4'b0000);
    counters();
  endtask
  task automatic step(input logic [31:0] ins, input logic z);
    dec_t       d;
    logic       tk, raw;
    logic [4:0] mrd;
    d = model(ins);
    mrd = prev[11:7];
    inst_control = ins[6:0];
    inst_alu     = {ins[31:25], ins[14:12]};
    ex_rs1       = ins[19:15];
    ex_rs2       = ins[24:20];
    mem_rd       = mrd;
    zero_flag    = z;
    tk  = m_valid & d.br & (z ^ ins[12]);
    raw = m_valid & m_mw[3] & (mrd != 5'd0) & ((mrd == ins[19:15]) | (d.rs2 & (mrd == ins[24:20])));
    exq.push_back({tk, tk, m_valid & d.src, m_valid ? d.op : 4'b0000, m_valid & d.ill, raw});
    mwq.push_back(m_valid ? d.ctl : 4'b0000);
    @(negedge clk);
    chk("ex", {sel, flush, alu_src, alu_op, illegal, raw_hazard}, exq.pop_front());
    chk("mw", {regwq, memwq, memrq, mem2regq}, mwq.pop_front());
    counters();
    m_cyc++;
    m_ret += int'(m_mv);
    m_fl  += int'(tk);
    m_mv    = m_valid & ~d.ill;
    m_mw    = m_valid ? d.ctl : 4'b0000;
    m_valid = ~tk;
    prev    = ins;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl = '{32'h002081B3, 32'h0040A283, 32'h00208063, 32'h00209063, 32'h0000007F,
            32'h022081B3, 32'h40118233, 32'h00208033, 32'h40100233, 32'h00518393,
            32'h4021D413, 32'h0020A023, 32'h0020A063, 32'h0031C2B3};
    @(posedge clk);
    #1;
    do_reset();
    step(32'h002081B3, 1'b0);
    step(32'h002081B3, 1'b0);
    step(32'h0040A283, 1'b0);
    step(32'h00518393, 1'b0);
    step(32'h0020A023, 1'b0);
    step(32'h00208063, 1'b1);
    step(32'h002081B3, 1'b0);
    step(32'h00209063, 1'b1);
    step(32'h00208063, 1'b1);
    step(32'h00208063, 1'b1);
    step(32'h00209063, 1'b0);
    step(32'h0000007F, 1'b0);
    step(32'h022081B3, 1'b0);
    step(32'h0020A063, 1'b0);
    step(32'h002081B3, 1'b0);
    step(32'h40118233, 1'b0);
    step(32'h00208033, 1'b0);
    step(32'h40100233, 1'b0);
    step(32'h4021D413, 1'b0);
    step(32'h0031C2B3, 1'b0);
    step(32'h002081B3, 1'b0);
    do_reset();
    step(32'h002081B3, 1'b0);
    for (int n = 0; n < 300; n++) begin
      step(tbl[$urandom_range(0, 13)], 1'($urandom_range(0, 1)));
      if (n == 150) do_reset();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
